// File: rtl/matmul_stream_ctrl.sv
// Streaming front/back end for the 4x4 matmul core: serial A/B in, start/valid handshake, serial C out.
// Optional WAIT watchdog with sticky err is compiled in when MM_TIMEOUT_EN is defined.
module matmul_stream_ctrl #(
  parameter int BIT_PREC       = 8,
  parameter int N              = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [BIT_PREC-1:0]               in_data,
  output logic                                     mm_start,
  output logic [N-1:0][N-1:0][BIT_PREC-1:0]        mm_A,
  output logic [N-1:0][N-1:0][BIT_PREC-1:0]        mm_B,
  input  logic [N-1:0][N-1:0][2*BIT_PREC:0]        mm_C,
  input  logic                                     mm_valid,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic signed [2*BIT_PREC:0]               out_data,
  output logic                                     out_last,
  output logic                                     busy,
  output logic                                     err
);

  localparam int              CW      = 2*BIT_PREC + 1;
  localparam int              RC_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(N - 1);

  typedef enum logic [2:0] {LOAD, START, WAIT, CAPT, DRAIN} state_e;

  state_e                      state_q, state_d;
  logic                        ld_mat;            // 0: filling A, 1: filling B
  logic [RC_W-1:0]             ld_row, ld_col;
  logic [RC_W-1:0]             dr_row, dr_col;
  logic [N-1:0][N-1:0][CW-1:0] c_buf;
  logic                        in_last, out_end, timeout;

  assign in_last = ld_mat && (ld_row == RC_LAST) && (ld_col == RC_LAST);
  assign out_end = (dr_row == RC_LAST) && (dr_col == RC_LAST);

  // NOTE: sequential state uses <= so every register sees pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    mm_start  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && in_last) state_d = START;
      end
      START: begin
        mm_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (mm_valid)     state_d = CAPT;
        else if (timeout) state_d = LOAD;
      end
      CAPT: state_d = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = out_end;
        if (out_ready && out_end) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Row-major loader: column wraps into row, row wraps into the A->B switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_mat <= 1'b0;
      ld_row <= '0;
      ld_col <= '0;
      mm_A   <= '0;
      mm_B   <= '0;
    end else if (state_q == LOAD && in_valid) begin
      if (ld_mat) mm_B[ld_row][ld_col] <= in_data;
      else        mm_A[ld_row][ld_col] <= in_data;
      if (ld_col == RC_LAST) begin
        ld_col <= '0;
        if (ld_row == RC_LAST) begin
          ld_row <= '0;
          ld_mat <= ~ld_mat;
        end else begin
          ld_row <= ld_row + 1'b1;
        end
      end else begin
        ld_col <= ld_col + 1'b1;
      end
    end
  end

  // NOTE: the C buffer is reset as well, so out_data reads 0 out of reset rather than X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_buf  <= '0;
      dr_row <= '0;
      dr_col <= '0;
    end else begin
      // The core presents C only after its valid cycle, hence capture in CAPT.
      if (state_q == CAPT) c_buf <= mm_C;
      if (state_q == DRAIN && out_ready) begin
        if (dr_col == RC_LAST) begin
          dr_col <= '0;
          dr_row <= (dr_row == RC_LAST) ? '0 : dr_row + 1'b1;
        end else begin
          dr_col <= dr_col + 1'b1;
        end
      end
    end
  end

  assign out_data = c_buf[dr_row][dr_col];

`ifdef MM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;

  assign timeout = (state_q == WAIT) && !mm_valid && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      wait_cnt <= (state_q == WAIT) ? wait_cnt + 16'd1 : 16'd0;
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Self-checking bench for matmul_stream_ctrl: the bench plays both the streamer and the matmul core.
// Define MM_TIMEOUT_EN to also exercise the watchdog.
module tb_matmul_stream_ctrl;

  localparam int BP = 8;
  localparam int N  = 4;
  localparam int NN = N*N;
  localparam int CW = 2*BP + 1;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          in_valid, in_ready;
  logic [BP-1:0]                 in_data;
  logic                          mm_start, mm_valid;
  logic [N-1:0][N-1:0][BP-1:0]   mm_A, mm_B;
  logic [N-1:0][N-1:0][CW-1:0]   mm_C;
  logic                          out_valid, out_ready, out_last, busy, err;
  logic [CW-1:0]                 out_data;

  always #5 clk = ~clk;

  matmul_stream_ctrl #(.BIT_PREC(BP), .N(N), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mm_start(mm_start), .mm_A(mm_A), .mm_B(mm_B), .mm_C(mm_C), .mm_valid(mm_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  int            passes = 0;
  int            total  = 0;
  int            a [N][N];
  int            b [N][N];
  logic [CW-1:0] exp_c [NN];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Plain matrix product; a sum that exceeds 17 bits keeps only its 17-bit pattern.
  task automatic build_ref();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += a[i][k] * b[k][j];
        exp_c[i*N + j] = CW'(s);
      end
  endtask

  function automatic logic [N-1:0][N-1:0][BP-1:0] pack_op(input bit sel_b);
    logic [N-1:0][N-1:0][BP-1:0] r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = BP'(sel_b ? b[i][j] : a[i][j]);
    return r;
  endfunction

  // Core behaviour: multiplies whatever operands the controller presents.
  function automatic logic [N-1:0][N-1:0][CW-1:0] core_product();
    logic [N-1:0][N-1:0][CW-1:0] r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'($signed(mm_A[i][k])) * int'($signed(mm_B[k][j]));
        r[i][j] = CW'(s);
      end
    return r;
  endfunction

  task automatic scramble_c();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mm_C[i][j] = CW'($urandom);
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a[i][j] = int'($urandom_range(0, 255)) - 128;
        b[i][j] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  // Streams the first n_elem elements of A then B; returns on the negedge after the last handshake.
  task automatic load(input int n_elem, input int stall_pct);
    for (int idx = 0; idx < n_elem; idx++) begin
      int v;
      v = (idx < NN) ? a[idx/N][idx%N] : b[(idx-NN)/N][(idx-NN)%N];
      while (stall_pct > 0 && int'($urandom_range(0, 99)) < stall_pct) begin
        in_valid = 1'b0;
        in_data  = BP'($urandom);
        @(negedge clk);
      end
      if (idx == 0) begin
        check("load_in_ready", in_ready, 1);
        check("load_busy", busy, 0);
      end
      in_valid = 1'b1;
      in_data  = BP'(v);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_matrix(input int in_stall, input int out_stall, input int lat, input bit glitch);
    int  k, cyc;
    bit  glitched;
    build_ref();
    scramble_c();
    load(2*NN, in_stall);
    // START
    check("start_pulse", mm_start, 1);
    check("start_in_ready", in_ready, 0);
    check("start_busy", busy, 1);
    check("start_mm_A", mm_A, pack_op(1'b0));
    check("start_mm_B", mm_B, pack_op(1'b1));
    @(negedge clk);
    check("start_one_cycle", mm_start, 0);
    repeat (lat) @(negedge clk);
    mm_valid = 1'b1;
    @(posedge clk);
    #1 mm_C = core_product();
    @(negedge clk);
    mm_valid = 1'b0;
    check("capt_no_out_valid", out_valid, 0);
    check("capt_mm_A_stable", mm_A, pack_op(1'b0));
    check("capt_mm_B_stable", mm_B, pack_op(1'b1));
    @(posedge clk);
    #1 scramble_c();
    @(negedge clk);
    // DRAIN
    k = 0;
    cyc = 0;
    glitched = 1'b0;
    while (k < NN && cyc < 2000) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, exp_c[k]);
      check("drain_last", out_last, (k == NN-1) ? 1 : 0);
      out_ready = (out_stall > 0 && int'($urandom_range(0, 99)) < out_stall) ? 1'b0 : 1'b1;
      if (glitch && k == 5 && !glitched) begin
        mm_valid  = 1'b1;
        out_ready = 1'b0;
        glitched  = 1'b1;
        scramble_c();
      end
      @(posedge clk);
      if (out_ready) k++;
      @(negedge clk);
      mm_valid = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_complete", k, NN);
    check("post_drain_out_valid", out_valid, 0);
    check("post_drain_in_ready", in_ready, 1);
    check("post_drain_busy", busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    mm_valid  = 1'b0;
    out_ready = 1'b0;
    mm_C      = '0;
    #12 rst = 1'b0;
    @(negedge clk);

    check("rst_in_ready", in_ready, 1);
    check("rst_mm_start", mm_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_mm_A", mm_A, 0);
    check("rst_mm_B", mm_B, 0);
    check("rst_out_data", out_data, 0);

    // Stray core valid while loading is ignored.
    mm_valid = 1'b1;
    scramble_c();
    @(negedge clk);
    mm_valid = 1'b0;
    check("load_valid_busy", busy, 0);
    check("load_valid_in_ready", in_ready, 1);
    check("load_valid_start", mm_start, 0);

    // Identity times 1..16 streams 1..16 back.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a[i][j] = (i == j) ? 1 : 0;
        b[i][j] = 4*i + j + 1;
      end
    run_matrix(0, 0, 3, 1'b0);

    // Extreme operands.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a[i][j] = -128;
        b[i][j] = -128;
      end
    run_matrix(0, 0, 1, 1'b0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) a[i][j] = 127;
    run_matrix(0, 0, 0, 1'b0);

    // Reset mid-load discards the partial matrix.
    randomize_ops();
    load(10, 0);
    #2 rst = 1'b1;
    #1;
    check("midload_rst_in_ready", in_ready, 1);
    check("midload_rst_busy", busy, 0);
    check("midload_rst_mm_A", mm_A, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    randomize_ops();
    run_matrix(30, 30, 2, 1'b1);

`ifdef MM_TIMEOUT_EN
    // Core never answers: err after 20 WAIT cycles, nothing streamed.
    randomize_ops();
    load(2*NN, 0);
    check("to_start", mm_start, 1);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check("to_err_low", err, 0);
      check("to_no_out", out_valid, 0);
    end
    @(negedge clk);
    check("to_err_set", err, 1);
    check("to_back_load", in_ready, 1);
    check("to_no_out_after", out_valid, 0);
    randomize_ops();
    run_matrix(0, 0, 4, 1'b0);
    check("to_err_sticky", err, 1);
`endif

    // Random matrices with 50% stalls on both streams.
    for (int m = 0; m < 100; m++) begin
      randomize_ops();
      run_matrix(50, 50, int'($urandom_range(0, 7)), 1'b0);
    end

`ifdef MM_TIMEOUT_EN
    check("final_err", err, 1);
`else
    check("final_err", err, 0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
